forwarding_alu_stage: RTL and testbench

Execute-stage block of the 5-stage MIPS pipeline. It resolves both source operands by forwarding from the EX/MEM register it owns, from the MEM/WB write-back bus, or from a one-entry hold register. It detects load-use hazards and stalls, selects the ALU inputs and computes the ALU result. It then registers everything into the EX/MEM pipeline register, or inserts a bubble when it stalls.

---
 rtl/forwarding_alu_stage.sv | 194 +++++++++++++++++++
 tb/tb_forwarding_alu_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_alu_stage.sv
// forwarding_alu_stage
//   Execute stage of the 5-stage MIPS pipeline. Resolves rs/rt by forwarding from
//   the EX/MEM register held here, from the MEM/WB write-back bus, or from a one-entry
//   hold register. Detects load-use hazards, selects ALU inputs, computes the ALU result
//   and loads the EX/MEM register, or a bubble while stalling.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   ex_*                    ID/EX fields of the instruction currently in EX
//   wb_wr_addr/wb_wr_data   MEM/WB write-back bus (addr 0 = no write)
//   stall_ex                combinational; upstream holds ID/EX while high
//   mem_*                   EX/MEM pipeline register outputs
module forwarding_alu_stage #(
   parameter int unsigned CTRL_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       ex_pc,
   input  logic [CTRL_W-1:0] ex_ctrl,
   input  logic [4:0]        ex_rs_addr,
   input  logic [4:0]        ex_rt_addr,
   input  logic [31:0]       ex_rs_data,
   input  logic [31:0]       ex_rt_data,
   input  logic [1:0]        ex_need1,
   input  logic [1:0]        ex_need2,
   input  logic [2:0]        ex_src1_sel,
   input  logic [2:0]        ex_src2_sel,
   input  logic [15:0]       ex_imm16,
   input  logic [4:0]        ex_shamt,
   input  logic [3:0]        ex_alu_op,
   input  logic [4:0]        ex_wr_addr,
   input  logic [1:0]        ex_wr_src,
   input  logic [31:0]       ex_wr_data,
   input  logic [4:0]        wb_wr_addr,
   input  logic [31:0]       wb_wr_data,
   output logic              stall_ex,
   output logic [31:0]       mem_pc,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [4:0]        mem_wr_addr,
   output logic [31:0]       mem_wr_data,
   output logic              mem_wr_valid,
   output logic [31:0]       mem_alu_result,
   output logic [31:0]       mem_rs_data,
   output logic [31:0]       mem_rt_data
);

   typedef struct packed {
      logic        stall;
      logic [31:0] data;
   } fwd_t;

   logic        hold_valid_rs_q, hold_valid_rt_q;
   logic [31:0] hold_data_rs_q, hold_data_rt_q;

   fwd_t        rs_fwd, rt_fwd;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [31:0] wr_data_sel;
   logic        wr_valid_sel;

   // Priority: $0, EX/MEM (younger producer), MEM/WB, hold register, register file.
   // An EX/MEM producer whose value only appears in MEM stalls only consumers needing
   // the operand in EX; later consumers take the register-file value and pick up the
   // real value further down the pipe.
   function automatic fwd_t resolve(input logic [4:0]  addr,
                                    input logic [31:0] rf_data,
                                    input logic [1:0]  need,
                                    input logic        hold_valid,
                                    input logic [31:0] hold_data,
                                    input logic [4:0]  exm_addr,
                                    input logic        exm_valid,
                                    input logic [31:0] exm_data,
                                    input logic [4:0]  wb_addr,
                                    input logic [31:0] wb_data);
      fwd_t res;
      res.stall = 1'b0;
      res.data  = rf_data;
      if (addr == 5'd0) begin
         res.data = 32'h0;
      end else if (exm_addr == addr) begin
         if (exm_valid) res.data = exm_data;
         else           res.stall = (need == 2'd1);
      end else if (wb_addr == addr) begin
         res.data = wb_data;
      end else if (hold_valid) begin
         res.data = hold_data;
      end
      return res;
   endfunction

   function automatic logic [31:0] src_mux(input logic [2:0]  sel,
                                           input logic [31:0] rs_val,
                                           input logic [31:0] rt_val,
                                           input logic [15:0] imm,
                                           input logic [4:0]  shamt);
      logic [31:0] val;
      case (sel)
         3'd0:    val = rs_val;
         3'd1:    val = rt_val;
         3'd2:    val = {16'h0, imm};
         3'd3:    val = {{16{imm[15]}}, imm};
         3'd4:    val = {27'h0, shamt};
         default: val = 32'h0;
      endcase
      return val;
   endfunction

   always_comb begin
      rs_fwd = resolve(ex_rs_addr, ex_rs_data, ex_need1, hold_valid_rs_q, hold_data_rs_q,
                       mem_wr_addr, mem_wr_valid, mem_wr_data, wb_wr_addr, wb_wr_data);
      rt_fwd = resolve(ex_rt_addr, ex_rt_data, ex_need2, hold_valid_rt_q, hold_data_rt_q,
                       mem_wr_addr, mem_wr_valid, mem_wr_data, wb_wr_addr, wb_wr_data);
      stall_ex = rs_fwd.stall | rt_fwd.stall;
   end

   assign alu_a = src_mux(ex_src1_sel, rs_fwd.data, rt_fwd.data, ex_imm16, ex_shamt);
   assign alu_b = src_mux(ex_src2_sel, rs_fwd.data, rt_fwd.data, ex_imm16, ex_shamt);

   always_comb begin
      alu_result = 32'h0;
      case (ex_alu_op)
         4'd0, 4'd1: alu_result = alu_a + alu_b;
         4'd2, 4'd3: alu_result = alu_a - alu_b;
         4'd4:       alu_result = alu_a & alu_b;
         4'd5:       alu_result = alu_a | alu_b;
         4'd6:       alu_result = alu_a ^ alu_b;
         4'd7:       alu_result = ~(alu_a | alu_b);
         4'd8:       alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
         4'd9:       alu_result = {31'h0, alu_a < alu_b};
         4'd10:      alu_result = alu_b << alu_a[4:0];
         4'd11:      alu_result = alu_b >> alu_a[4:0];
         4'd12:      alu_result = $unsigned($signed(alu_b) >>> alu_a[4:0]);
         4'd13:      alu_result = {alu_b[15:0], 16'h0};
         default:    alu_result = 32'h0;
      endcase
   end

   // Loads (wr_src 2/3) carry ex_wr_data marked not valid; the real value is produced in MEM.
   always_comb begin
      wr_data_sel  = ex_wr_data;
      wr_valid_sel = 1'b0;
      case (ex_wr_src)
         2'd0: begin
            wr_data_sel  = alu_result;
            wr_valid_sel = 1'b1;
         end
         2'd1:    wr_valid_sel = 1'b1;
         default: wr_valid_sel = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_pc          <= 32'h0;
         mem_ctrl        <= '0;
         mem_wr_addr     <= 5'h0;
         mem_wr_data     <= 32'h0;
         mem_wr_valid    <= 1'b0;
         mem_alu_result  <= 32'h0;
         mem_rs_data     <= 32'h0;
         mem_rt_data     <= 32'h0;
         hold_valid_rs_q <= 1'b0;
         hold_valid_rt_q <= 1'b0;
         hold_data_rs_q  <= 32'h0;
         hold_data_rt_q  <= 32'h0;
      end else if (stall_ex) begin
         // Bubble downstream; capture any operand that resolved this cycle, since a
         // MEM/WB value will have moved on by the time the stall clears.
         mem_pc          <= 32'h0;
         mem_ctrl        <= '0;
         mem_wr_addr     <= 5'h0;
         mem_wr_data     <= 32'h0;
         mem_wr_valid    <= 1'b0;
         mem_alu_result  <= 32'h0;
         mem_rs_data     <= 32'h0;
         mem_rt_data     <= 32'h0;
         hold_valid_rs_q <= ~rs_fwd.stall;
         hold_valid_rt_q <= ~rt_fwd.stall;
         hold_data_rs_q  <= rs_fwd.data;
         hold_data_rt_q  <= rt_fwd.data;
      end else begin
         mem_pc          <= ex_pc;
         mem_ctrl        <= ex_ctrl;
         mem_wr_addr     <= ex_wr_addr;
         mem_wr_data     <= wr_data_sel;
         mem_wr_valid    <= wr_valid_sel;
         mem_alu_result  <= alu_result;
         mem_rs_data     <= rs_fwd.data;
         mem_rt_data     <= rt_fwd.data;
         hold_valid_rs_q <= 1'b0;
         hold_valid_rt_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_forwarding_alu_stage.sv
// tb_forwarding_alu_stage
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the execute stage kept in this file.
module tb_forwarding_alu_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ex_pc, ex_ctrl, ex_rs_data, ex_rt_data, ex_wr_data, wb_wr_data;
   logic [4:0]  ex_rs_addr, ex_rt_addr, ex_shamt, ex_wr_addr, wb_wr_addr;
   logic [1:0]  ex_need1, ex_need2, ex_wr_src;
   logic [2:0]  ex_src1_sel, ex_src2_sel;
   logic [15:0] ex_imm16;
   logic [3:0]  ex_alu_op;
   logic        stall_ex, mem_wr_valid;
   logic [31:0] mem_pc, mem_ctrl, mem_wr_data, mem_alu_result, mem_rs_data, mem_rt_data;
   logic [4:0]  mem_wr_addr;

   forwarding_alu_stage #(.CTRL_W(32)) dut (
      .clock(clock), .reset(reset), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
      .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rs_data(ex_rs_data),
      .ex_rt_data(ex_rt_data), .ex_need1(ex_need1), .ex_need2(ex_need2),
      .ex_src1_sel(ex_src1_sel), .ex_src2_sel(ex_src2_sel), .ex_imm16(ex_imm16),
      .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op), .ex_wr_addr(ex_wr_addr),
      .ex_wr_src(ex_wr_src), .ex_wr_data(ex_wr_data), .wb_wr_addr(wb_wr_addr),
      .wb_wr_data(wb_wr_data), .stall_ex(stall_ex), .mem_pc(mem_pc), .mem_ctrl(mem_ctrl),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid),
      .mem_alu_result(mem_alu_result), .mem_rs_data(mem_rs_data), .mem_rt_data(mem_rt_data)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Model of the EX/MEM register and the two hold entries.
   logic [31:0] m_pc, m_ctrl, m_wr_data, m_alu, m_rs, m_rt, hd_rs, hd_rt;
   logic [4:0]  m_wr_addr;
   logic        m_wr_valid, hv_rs, hv_rt, last_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      {m_pc, m_ctrl, m_wr_data, m_alu, m_rs, m_rt, hd_rs, hd_rt} = '0;
      m_wr_addr = 5'd0;
      {m_wr_valid, hv_rs, hv_rt, last_stall} = 4'b0;
   endtask

   // Returns {stall, value} for one source operand.
   function automatic logic [32:0] m_fwd(input logic [4:0] r, input logic [31:0] rf,
                                         input logic [1:0] need, input logic hv,
                                         input logic [31:0] hd);
      if (r == 5'd0) return 33'h0;
      if (m_wr_addr == r) begin
         if (m_wr_valid) return {1'b0, m_wr_data};
         return {need == 2'd1, rf};
      end
      if (wb_wr_addr == r) return {1'b0, wb_wr_data};
      if (hv) return {1'b0, hd};
      return {1'b0, rf};
   endfunction

   function automatic logic [31:0] m_src(input logic [2:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
      int signed simm;
      simm = int'($signed(ex_imm16));
      case (sel)
         3'd0:    return a;
         3'd1:    return b;
         3'd2:    return 32'(ex_imm16);
         3'd3:    return 32'(simm);
         3'd4:    return 32'(ex_shamt);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_alu_fn(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      longint unsigned ua, ub;
      longint signed   sa, sb;
      int unsigned     sh;
      ua = 64'(a); ub = 64'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sh = a % 32;
      case (op)
         4'd0, 4'd1: return 32'(ua + ub);
         4'd2, 4'd3: return 32'(ua - ub);
         4'd4:       return a & b;
         4'd5:       return a | b;
         4'd6:       return a ^ b;
         4'd7:       return ~(a | b);
         4'd8:       return (sa < sb) ? 32'd1 : 32'd0;
         4'd9:       return (ua < ub) ? 32'd1 : 32'd0;
         4'd10:      return 32'(ub * (64'd1 << sh));
         4'd11:      return 32'(ub / (64'd1 << sh));
         4'd12:      return 32'(sb >>> sh);
         4'd13:      return 32'(ub * 64'd65536);
         default:    return 32'h0;
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".pc"},    mem_pc, m_pc);
      check({tag, ".ctrl"},  mem_ctrl, m_ctrl);
      check({tag, ".waddr"}, 32'(mem_wr_addr), 32'(m_wr_addr));
      check({tag, ".wdata"}, mem_wr_data, m_wr_data);
      check({tag, ".wvld"},  32'(mem_wr_valid), 32'(m_wr_valid));
      check({tag, ".alu"},   mem_alu_result, m_alu);
      check({tag, ".rs"},    mem_rs_data, m_rs);
      check({tag, ".rt"},    mem_rt_data, m_rt);
   endtask

   // Called just after a falling edge with inputs driven; ends at the next falling edge.
   task automatic step(input string tag);
      logic [32:0] fr, ft;
      logic        st;
      logic [31:0] a, b, res;
      #1;
      fr = m_fwd(ex_rs_addr, ex_rs_data, ex_need1, hv_rs, hd_rs);
      ft = m_fwd(ex_rt_addr, ex_rt_data, ex_need2, hv_rt, hd_rt);
      st = fr[32] | ft[32];
      check({tag, ".stall"}, 32'(stall_ex), 32'(st));
      a   = m_src(ex_src1_sel, fr[31:0], ft[31:0]);
      b   = m_src(ex_src2_sel, fr[31:0], ft[31:0]);
      res = m_alu_fn(ex_alu_op, a, b);
      @(posedge clock);
      #1;
      if (st) begin
         {m_pc, m_ctrl, m_wr_data, m_alu, m_rs, m_rt} = '0;
         m_wr_addr = 5'd0; m_wr_valid = 1'b0;
         hv_rs = ~fr[32]; hd_rs = fr[31:0];
         hv_rt = ~ft[32]; hd_rt = ft[31:0];
      end else begin
         m_pc = ex_pc; m_ctrl = ex_ctrl; m_wr_addr = ex_wr_addr; m_alu = res;
         m_wr_data  = (ex_wr_src == 2'd0) ? res : ex_wr_data;
         m_wr_valid = (ex_wr_src < 2'd2);
         m_rs = fr[31:0]; m_rt = ft[31:0];
         hv_rs = 1'b0; hv_rt = 1'b0;
      end
      last_stall = st;
      check_outputs(tag);
      @(negedge clock);
   endtask

   task automatic nop();
      ex_pc = $urandom; ex_ctrl = $urandom;
      ex_rs_addr = 5'd0; ex_rt_addr = 5'd0; ex_rs_data = 32'h0; ex_rt_data = 32'h0;
      ex_need1 = 2'd0; ex_need2 = 2'd0; ex_src1_sel = 3'd0; ex_src2_sel = 3'd1;
      ex_imm16 = 16'h0; ex_shamt = 5'd0; ex_alu_op = 4'd1;
      ex_wr_addr = 5'd0; ex_wr_src = 2'd0; ex_wr_data = 32'h0;
      wb_wr_addr = 5'd0; wb_wr_data = 32'h0;
   endtask

   task automatic load(input logic [4:0] r);
      nop();
      ex_wr_addr = r; ex_wr_src = 2'd2; ex_wr_data = 32'hDEAD_0000;
   endtask

   initial begin
      nop();
      model_clear();
      #12;
      check_outputs("reset");
      check("reset.stall", 32'(stall_ex), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Plain ADDU.
      nop();
      ex_rs_addr = 5'd5; ex_rt_addr = 5'd6; ex_rs_data = 32'd3; ex_rt_data = 32'd4;
      ex_wr_addr = 5'd10;
      step("addu");
      check("addu.result", mem_alu_result, 32'd7);
      check("addu.valid", 32'(mem_wr_valid), 32'd1);

      // EX/MEM forward of an ALU result.
      nop();
      ex_src1_sel = 3'd2; ex_src2_sel = 3'd5; ex_imm16 = 16'h0010; ex_alu_op = 4'd5;
      ex_wr_addr = 5'd8;
      step("fwd.prod");
      nop();
      ex_rs_addr = 5'd8; ex_rs_data = 32'hDEAD;
      step("fwd.cons");
      check("fwd.rs", mem_rs_data, 32'h10);

      // Back-to-back load-use: one stall then MEM/WB forward.
      load(5'd9);
      step("lu.load");
      nop();
      ex_rs_addr = 5'd9; ex_need1 = 2'd1; ex_rs_data = 32'h1;
      step("lu.stall");
      check("lu.bubble", 32'(mem_wr_addr), 32'd0);
      check("lu.stalled", 32'(last_stall), 32'd1);
      wb_wr_addr = 5'd9; wb_wr_data = 32'hAB;
      step("lu.resume");
      check("lu.result", mem_alu_result, 32'hAB);
      check("lu.nostall", 32'(last_stall), 32'd0);

      // Store data needed only in MEM: no stall.
      load(5'd12);
      step("st.load");
      nop();
      ex_rt_addr = 5'd12; ex_need2 = 2'd2; ex_rt_data = 32'h1234;
      step("st.use");
      check("st.rt", mem_rt_data, 32'h1234);

      // Hold register keeps a WB-forwarded rt across a stall.
      load(5'd9);
      step("hold.load");
      nop();
      ex_rs_addr = 5'd9; ex_need1 = 2'd1; ex_rs_data = 32'h1;
      ex_rt_addr = 5'd7; ex_rt_data = 32'h11; wb_wr_addr = 5'd7; wb_wr_data = 32'h55;
      step("hold.stall");
      wb_wr_addr = 5'd0; wb_wr_data = 32'h0;
      step("hold.use");
      check("hold.rt", mem_rt_data, 32'h55);

      // ALU corner cases.
      nop();
      ex_src1_sel = 3'd4; ex_shamt = 5'd4; ex_rt_addr = 5'd3; ex_rt_data = 32'h8000_0000;
      ex_alu_op = 4'd12;
      step("sra");
      check("sra.result", mem_alu_result, 32'hF800_0000);
      nop();
      ex_rs_addr = 5'd1; ex_rs_data = 32'hFFFF_FFFF; ex_rt_addr = 5'd2; ex_rt_data = 32'd1;
      ex_alu_op = 4'd8;
      step("slt");
      check("slt.result", mem_alu_result, 32'd1);
      ex_alu_op = 4'd9;
      step("sltu");
      check("sltu.result", mem_alu_result, 32'd0);

      // Reset in the middle of a stall cycle.
      load(5'd9);
      step("rst.load");
      nop();
      ex_rs_addr = 5'd9; ex_need1 = 2'd1;
      #1;
      check("rst.pre_stall", 32'(stall_ex), 32'd1);
      reset = 1'b1;
      #1;
      model_clear();
      check_outputs("rst.mid");
      check("rst.stall", 32'(stall_ex), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Randomized traffic over a small register set to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            ex_pc = $urandom; ex_ctrl = $urandom;
            ex_rs_addr = 5'($urandom_range(0, 3)); ex_rt_addr = 5'($urandom_range(0, 3));
            ex_rs_data = $urandom; ex_rt_data = $urandom;
            ex_need1 = 2'($urandom); ex_need2 = 2'($urandom);
            ex_src1_sel = 3'($urandom); ex_src2_sel = 3'($urandom);
            ex_imm16 = 16'($urandom); ex_shamt = 5'($urandom); ex_alu_op = 4'($urandom);
            ex_wr_addr = 5'($urandom_range(0, 3)); ex_wr_src = 2'($urandom);
            ex_wr_data = $urandom;
         end
         wb_wr_addr = 5'($urandom_range(0, 4)); wb_wr_data = $urandom;
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
